// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the 8-bit ALU, its issue/retire controller
// and the branch-condition evaluator.
//   ALU_OP_*  : 3-bit ALU opcodes
//   FLAG_*    : bit positions inside the 4-bit ZNCV flag vector
//   COND_*    : 3-bit branch condition selects
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_OP_ADD  = 3'd0;
  localparam logic [2:0] ALU_OP_SUB  = 3'd1;
  localparam logic [2:0] ALU_OP_AND  = 3'd2;
  localparam logic [2:0] ALU_OP_OR   = 3'd3;
  localparam logic [2:0] ALU_OP_XOR  = 3'd4;
  localparam logic [2:0] ALU_OP_SHL  = 3'd5;
  localparam logic [2:0] ALU_OP_SHR  = 3'd6;
  localparam logic [2:0] ALU_OP_PASS = 3'd7;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_CS = 3'd2;
  localparam logic [2:0] COND_CC = 3'd3;
  localparam logic [2:0] COND_MI = 3'd4;
  localparam logic [2:0] COND_PL = 3'd5;
  localparam logic [2:0] COND_VS = 3'd6;
  localparam logic [2:0] COND_AL = 3'd7;

  // Per-bit flag update: bits selected by mask take upd, others keep cur.
  function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                             input logic [3:0] upd,
                                             input logic [3:0] mask);
    return (cur & ~mask) | (upd & mask);
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: request and result handshakes of the ALU issue/retire controller.
//   request : in_valid/in_ready, in_op, in_shamt, in_a, in_b, in_fmask (ZNCV)
//   result  : res_valid/res_ready, res_data, res_flags (raw ZNCV)
//   master  : requester/consumer side; slave : controller side
interface alu_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_shamt;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_fmask;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flags;

  modport master (
    output in_valid, in_op, in_shamt, in_a, in_b, in_fmask, res_ready,
    input  in_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  in_valid, in_op, in_shamt, in_a, in_b, in_fmask, res_ready,
    output in_ready, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/alu.sv
// alu: 8-bit clocked ALU with STAGES register stages between operands and
// out/flags. Flags are ZNCV; C is carry-out for ADD, borrow for SUB, 0 else;
// V is signed overflow for ADD/SUB, 0 else.
//   clk in; a, b in 8; op in 3; shamt in 3; out out 8; flags out 4
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic       clk,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  input  logic [2:0] shamt,
  output logic [7:0] out,
  output logic [3:0] flags
);

  logic [8:0]  sum;
  logic [7:0]  res;
  logic        c;
  logic        v;
  logic [11:0] pipe_p [STAGES];

  always_comb begin
    sum = 9'd0;
    res = 8'd0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ALU_OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[7:0];
        c   = sum[8];
        v   = (a[7] == b[7]) && (res[7] != a[7]);
      end
      ALU_OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        res = sum[7:0];
        c   = sum[8];
        v   = (a[7] != b[7]) && (res[7] != a[7]);
      end
      ALU_OP_AND: res = a & b;
      ALU_OP_OR:  res = a | b;
      ALU_OP_XOR: res = a ^ b;
      ALU_OP_SHL: res = a << shamt;
      ALU_OP_SHR: res = a >> shamt;
      default:    res = a;
    endcase
  end

  // Stage boundary: result registers, STAGES deep
  always_ff @(posedge clk) begin
    pipe_p[0] <= {res, (res == 8'd0), res[7], c, v};
    for (int i = 1; i < STAGES; i++) pipe_p[i] <= pipe_p[i-1];
  end

  assign {out, flags} = pipe_p[STAGES-1];

endmodule

// File: rtl/alu_cond.sv
// alu_cond: evaluates a 3-bit branch condition against a ZNCV flag vector.
//   cond      in  3  condition select (COND_* encoding)
//   flags     in  4  [3]=Z [2]=N [1]=C [0]=V
//   cond_true out 1  condition holds
module alu_cond
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      COND_EQ: cond_true =  flags[FLAG_Z];
      COND_NE: cond_true = ~flags[FLAG_Z];
      COND_CS: cond_true =  flags[FLAG_C];
      COND_CC: cond_true = ~flags[FLAG_C];
      COND_MI: cond_true =  flags[FLAG_N];
      COND_PL: cond_true = ~flags[FLAG_N];
      COND_VS: cond_true =  flags[FLAG_V];
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: issue/retire controller for the clocked 8-bit ALU.
// Accepts one operation on bus (request side), holds operands on alu_* for
// the ALU's latency, captures alu_out/alu_flags, retires them on bus (result
// side) and maintains the masked architectural ZNCV register flags_q with a
// condition evaluator (cond -> cond_true).
//   clk, rst (async, active-high); bus : alu_ctrl_if.slave
//   alu_a/alu_b/alu_op/alu_shamt out; alu_out/alu_flags in
//   flags_q out 4; cond in 3; cond_true out 1
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int         ALU_LAT   = 1,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  alu_ctrl_if.slave  bus,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic [2:0] alu_shamt,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags_q,
  input  logic [2:0] cond,
  output logic       cond_true
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

  state_t     state, state_d;
  logic [1:0] lat_cnt;
  logic [3:0] fmask_q;
  logic [7:0] res_data_q;
  logic [3:0] res_flags_q;
  logic       res_valid_q;
  logic       accept, capture, retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // ISSUE is the presentation cycle; the counter then runs in WAIT so the
  // capture edge falls ALU_LAT+1 edges after the accept edge.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (lat_cnt == 2'd0) begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.res_ready) begin
        retire  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: operand presentation, latency count, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a       <= 8'd0;
      alu_b       <= 8'd0;
      alu_op      <= 3'd0;
      alu_shamt   <= 3'd0;
      fmask_q     <= 4'd0;
      lat_cnt     <= 2'd0;
      res_data_q  <= 8'd0;
      res_flags_q <= 4'd0;
      res_valid_q <= 1'b0;
      flags_q     <= FLAGS_RST;
    end else begin
      if (accept) begin
        alu_a     <= bus.in_a;
        alu_b     <= bus.in_b;
        alu_op    <= bus.in_op;
        alu_shamt <= bus.in_shamt;
        fmask_q   <= bus.in_fmask;
        lat_cnt   <= LAT_LOAD;
      end
      if (state == WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      if (capture) begin
        res_data_q  <= alu_out;
        res_flags_q <= alu_flags;
        flags_q     <= merge_flags(flags_q, alu_flags, fmask_q);
        res_valid_q <= 1'b1;
      end
      if (retire) res_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;

  alu_cond u_cond (
    .cond      (cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  alu_ctrl_if bus1();
  alu_ctrl_if bus3();

  logic [7:0] alu_a1, alu_b1, alu_out1, alu_a3, alu_b3, alu_out3;
  logic [2:0] alu_op1, alu_sh1, alu_op3, alu_sh3, cond1, cond3;
  logic [3:0] alu_fl1, flags_q1, alu_fl3, flags_q3;
  logic       ct1, ct3;

  int n_chk = 0;
  int n_bad = 0;

  alu_ctrl #(.ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_shamt(alu_sh1),
    .alu_out(alu_out1), .alu_flags(alu_fl1),
    .flags_q(flags_q1), .cond(cond1), .cond_true(ct1)
  );
  alu #(.STAGES(1)) u_alu1 (
    .clk(clk), .a(alu_a1), .b(alu_b1), .op(alu_op1), .shamt(alu_sh1),
    .out(alu_out1), .flags(alu_fl1)
  );

  alu_ctrl #(.ALU_LAT(3), .FLAGS_RST(4'b0011)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_shamt(alu_sh3),
    .alu_out(alu_out3), .alu_flags(alu_fl3),
    .flags_q(flags_q3), .cond(cond3), .cond_true(ct3)
  );
  alu #(.STAGES(3)) u_alu3 (
    .clk(clk), .a(alu_a3), .b(alu_b3), .op(alu_op3), .shamt(alu_sh3),
    .out(alu_out3), .flags(alu_fl3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one request; returns #1 after the accept edge.
  task automatic send1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fm);
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_op = op; bus1.in_a = a; bus1.in_b = b;
    bus1.in_fmask = fm; bus1.in_shamt = 3'd0;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic send3(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fm);
    @(negedge clk);
    bus3.in_valid = 1'b1; bus3.in_op = op; bus3.in_a = a; bus3.in_b = b;
    bus3.in_fmask = fm; bus3.in_shamt = 3'd0;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
  endtask

  task automatic wait_res1(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus1.res_valid) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic retire1();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus1.in_valid = 1'b0; bus1.in_op = 3'd0; bus1.in_shamt = 3'd0; bus1.in_a = 8'd0;
    bus1.in_b = 8'd0; bus1.in_fmask = 4'd0; bus1.res_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.in_op = 3'd0; bus3.in_shamt = 3'd0; bus3.in_a = 8'd0;
    bus3.in_b = 8'd0; bus3.in_fmask = 4'd0; bus3.res_ready = 1'b1;
    cond1 = 3'd0; cond3 = 3'd0;
    rst1 = 1'b1; rst3 = 1'b1;
    #12;
    chk("rst_in_ready",  32'(bus1.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bus1.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus1.res_data), 32'd0);
    chk("rst_flags_q",   32'(flags_q1), 32'd0);
    chk("rst_alu_a",     32'(alu_a1), 32'd0);
    chk("rst3_flags_q",  32'(flags_q3), 32'h3);
    chk("rst3_in_ready", 32'(bus3.in_ready), 32'd1);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    // 0x7F + 0x01: signed overflow into 0x80
    send1(ALU_OP_ADD, 8'h7F, 8'h01, 4'hF);
    chk("t1_rv_n", 32'(bus1.res_valid), 32'd0);
    chk("t1_alu_a", 32'(alu_a1), 32'h7F);
    @(posedge clk); #1;
    chk("t1_rv_n1", 32'(bus1.res_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_rv_n2", 32'(bus1.res_valid), 32'd1);
    chk("t1_data", 32'(bus1.res_data), 32'h80);
    chk("t1_rflags", 32'(bus1.res_flags), 32'h5);
    chk("t1_flags_q", 32'(flags_q1), 32'h5);
    chk("t1_in_ready_done", 32'(bus1.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("t1_in_ready_back", 32'(bus1.in_ready), 32'd1);
    chk("t1_rv_cleared", 32'(bus1.res_valid), 32'd0);

    // Backpressure: 0x80 + 0x80 -> 0x00, ZNCV=1011
    bus1.res_ready = 1'b0;
    send1(ALU_OP_ADD, 8'h80, 8'h80, 4'hF);
    wait_res1("bp_wait");
    chk("bp_data0", 32'(bus1.res_data), 32'h00);
    chk("bp_rflags0", 32'(bus1.res_flags), 32'hB);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus1.in_valid = 1'b1; bus1.in_a = 8'h55; bus1.in_b = 8'h11;
      end else begin
        bus1.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp_data", 32'(bus1.res_data), 32'h00);
      chk("bp_rflags", 32'(bus1.res_flags), 32'hB);
      chk("bp_in_ready", 32'(bus1.in_ready), 32'd0);
      chk("bp_rv", 32'(bus1.res_valid), 32'd1);
      chk("bp_alu_a", 32'(alu_a1), 32'h80);
    end
    bus1.in_valid = 1'b0;
    chk("bp_flags_q", 32'(flags_q1), 32'hB);
    bus1.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_retire_rv", 32'(bus1.res_valid), 32'd0);
    chk("bp_retire_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_ghost", 32'(bus1.res_valid), 32'd0);

    // 0xFF + 0x01 -> 0x00 with Z and C
    send1(ALU_OP_ADD, 8'hFF, 8'h01, 4'hF);
    wait_res1("t2_wait");
    chk("t2_data", 32'(bus1.res_data), 32'h00);
    chk("t2_flags_q", 32'(flags_q1), 32'hA);
    retire1();
    cond1 = COND_EQ; #1 chk("cond_eq", 32'(ct1), 32'd1);
    cond1 = COND_NE; #1 chk("cond_ne", 32'(ct1), 32'd0);
    cond1 = COND_CS; #1 chk("cond_cs", 32'(ct1), 32'd1);
    cond1 = COND_CC; #1 chk("cond_cc", 32'(ct1), 32'd0);
    cond1 = COND_AL; #1 chk("cond_al", 32'(ct1), 32'd1);

    // Only N may update: Z and C survive
    send1(ALU_OP_ADD, 8'h01, 8'h01, 4'b0100);
    wait_res1("t4_wait");
    chk("t4_data", 32'(bus1.res_data), 32'h02);
    chk("t4_rflags", 32'(bus1.res_flags), 32'h0);
    chk("t4_flags_q", 32'(flags_q1), 32'hA);
    retire1();

    // Empty mask: flags_q untouched, result still retired
    send1(ALU_OP_ADD, 8'h7F, 8'h01, 4'b0000);
    wait_res1("t5_wait");
    chk("t5_rflags", 32'(bus1.res_flags), 32'h5);
    chk("t5_flags_q", 32'(flags_q1), 32'hA);
    retire1();
    chk("t5_retired", 32'(bus1.res_valid), 32'd0);

    // 0x00 - 0x01 -> 0xFF with N and borrow
    send1(ALU_OP_SUB, 8'h00, 8'h01, 4'hF);
    wait_res1("t6_wait");
    chk("t6_data", 32'(bus1.res_data), 32'hFF);
    chk("t6_flags_q", 32'(flags_q1), 32'h6);
    retire1();
    cond1 = COND_MI; #1 chk("cond_mi", 32'(ct1), 32'd1);
    cond1 = COND_PL; #1 chk("cond_pl", 32'(ct1), 32'd0);
    cond1 = COND_VS; #1 chk("cond_vs", 32'(ct1), 32'd0);

    // ALU_LAT=3: valid first after edge N+4
    send3(ALU_OP_ADD, 8'h7F, 8'h01, 4'hF);
    chk("l3_rv_n", 32'(bus3.res_valid), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("l3_rv_early", 32'(bus3.res_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("l3_rv_n4", 32'(bus3.res_valid), 32'd1);
    chk("l3_data", 32'(bus3.res_data), 32'h80);
    chk("l3_flags_q", 32'(flags_q3), 32'h5);
    @(posedge clk); #1;
    chk("l3_in_ready", 32'(bus3.in_ready), 32'd1);

    // Asynchronous reset while in WAIT
    send3(ALU_OP_ADD, 8'hFF, 8'h01, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst3 = 1'b1;
    #1;
    chk("ar_in_ready", 32'(bus3.in_ready), 32'd1);
    chk("ar_rv", 32'(bus3.res_valid), 32'd0);
    chk("ar_data", 32'(bus3.res_data), 32'd0);
    chk("ar_flags_q", 32'(flags_q3), 32'h3);
    chk("ar_alu_a", 32'(alu_a3), 32'd0);
    chk("ar_alu_op", 32'(alu_op3), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("ar_no_rv", 32'(bus3.res_valid), 32'd0);
      chk("ar_flags_hold", 32'(flags_q3), 32'h3);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
